alu_arbiter: RTL and testbench

Two-port arbiter that shares a single combinational ALU (one `alu_if.alu` instance) between two requesters, e.g. the execute stage and a multicycle helper unit. It runs a req/ack handshake per port, round-robin grants on contention, drives registered operands into the ALU, and captures the ALU result and flags into per-port holding registers. Throughput is one operation every 2 cycles; it sits between the requesters and the ALU in the datapath.

---
 rtl/cpu_types_pkg.sv | 19 +
 rtl/alu_arbiter.sv | 124 ++++++++++++
 tb/tb_alu_arbiter.sv | 339 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: the machine word and the ALU opcode encoding.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [3:0] {
    ALU_SLL  = 4'd0,
    ALU_SRL  = 4'd1,
    ALU_ADD  = 4'd2,
    ALU_SUB  = 4'd3,
    ALU_AND  = 4'd4,
    ALU_OR   = 4'd5,
    ALU_XOR  = 4'd6,
    ALU_NOR  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } aluop_t;

endpackage

// File: rtl/alu_arbiter.sv
// Two-port round-robin arbiter sharing one combinational ALU: grant edge, capture edge, then a one-cycle ack.
// Requesters hold req and operands until their ack; a port is ignored during its own ack cycle.
module alu_arbiter
  import cpu_types_pkg::*;
(
  input  logic          CLK,
  input  logic          RST,

  input  logic          req0,
  input  aluop_t        aluop0,
  input  logic [31:0]   ra0,
  input  logic [31:0]   rb0,
  output logic          ack0,
  output logic [31:0]   out0,
  output logic          negative0,
  output logic          overflow0,
  output logic          zero0,

  input  logic          req1,
  input  aluop_t        aluop1,
  input  logic [31:0]   ra1,
  input  logic [31:0]   rb1,
  output logic          ack1,
  output logic [31:0]   out1,
  output logic          negative1,
  output logic          overflow1,
  output logic          zero1,

  output logic          busy,
  output logic          gnt,

  output aluop_t        alu_aluop,
  output logic [31:0]   alu_ra,
  output logic [31:0]   alu_rb,
  input  logic [31:0]   alu_out,
  input  logic          alu_negative,
  input  logic          alu_overflow,
  input  logic          alu_zero
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  logic [0:0] state;
  logic       last;
  logic       elig0;
  logic       elig1;
  logic       grant_any;
  logic       grant_sel;

  // A port is not eligible in its own ack cycle, so a held req re-arbitrates one edge later.
  always_comb begin
    elig0     = req0 & ~ack0;
    elig1     = req1 & ~ack1;
    grant_any = elig0 | elig1;
    if (elig0 && elig1) begin
      grant_sel = ~last;
    end else begin
      grant_sel = elig1;
    end
  end

  assign busy = (state == BUSY);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      gnt       <= 1'b0;
      last      <= 1'b1;
      ack0      <= 1'b0;
      ack1      <= 1'b0;
      out0      <= '0;
      negative0 <= 1'b0;
      overflow0 <= 1'b0;
      zero0     <= 1'b0;
      out1      <= '0;
      negative1 <= 1'b0;
      overflow1 <= 1'b0;
      zero1     <= 1'b0;
      alu_aluop <= aluop_t'(4'd0);
      alu_ra    <= '0;
      alu_rb    <= '0;
    end else begin
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      if (state == IDLE) begin
        if (grant_any) begin
          gnt   <= grant_sel;
          state <= BUSY;
          if (grant_sel) begin
            alu_aluop <= aluop1;
            alu_ra    <= ra1;
            alu_rb    <= rb1;
          end else begin
            alu_aluop <= aluop0;
            alu_ra    <= ra0;
            alu_rb    <= rb0;
          end
        end
      end else begin
        // ALU output has settled from the drive registers; only the granted port's holding regs change.
        if (gnt) begin
          out1      <= alu_out;
          negative1 <= alu_negative;
          overflow1 <= alu_overflow;
          zero1     <= alu_zero;
          ack1      <= 1'b1;
        end else begin
          out0      <= alu_out;
          negative0 <= alu_negative;
          overflow0 <= alu_overflow;
          zero0     <= alu_zero;
          ack0      <= 1'b1;
        end
        last  <= gnt;
        state <= IDLE;
      end
    end
  end

  a_ack_exclusive : assert property (@(posedge CLK) disable iff (RST) !(ack0 && ack1));
  a_busy_no_ack   : assert property (@(posedge CLK) disable iff (RST) !(busy && (ack0 || ack1)));

endmodule

// File: tb/tb_alu_arbiter.sv
// Randomized and directed bench for alu_arbiter against a transaction-timeline reference model.
module tb_alu_arbiter;
  import cpu_types_pkg::*;

  typedef struct packed {
    logic [31:0] out;
    logic        neg;
    logic        ovf;
    logic        zero;
  } res_t;

  logic        CLK = 1'b0;
  logic        RST;
  logic        req0, req1;
  aluop_t      aluop0, aluop1;
  logic [31:0] ra0, rb0, ra1, rb1;
  logic        ack0, ack1;
  logic [31:0] out0, out1;
  logic        negative0, overflow0, zero0;
  logic        negative1, overflow1, zero1;
  logic        busy, gnt;
  aluop_t      alu_aluop;
  logic [31:0] alu_ra, alu_rb;
  logic [31:0] alu_out;
  logic        alu_negative, alu_overflow, alu_zero;
  res_t        alu_res;

  int checks   = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  alu_arbiter dut (
    .CLK(CLK), .RST(RST),
    .req0(req0), .aluop0(aluop0), .ra0(ra0), .rb0(rb0), .ack0(ack0), .out0(out0),
    .negative0(negative0), .overflow0(overflow0), .zero0(zero0),
    .req1(req1), .aluop1(aluop1), .ra1(ra1), .rb1(rb1), .ack1(ack1), .out1(out1),
    .negative1(negative1), .overflow1(overflow1), .zero1(zero1),
    .busy(busy), .gnt(gnt),
    .alu_aluop(alu_aluop), .alu_ra(alu_ra), .alu_rb(alu_rb),
    .alu_out(alu_out), .alu_negative(alu_negative), .alu_overflow(alu_overflow), .alu_zero(alu_zero)
  );

  function automatic res_t alu_ref(input aluop_t op, input logic [31:0] a, input logic [31:0] b);
    res_t r;
    logic [4:0] sh;
    sh = b[4:0];
    r  = '0;
    case (op)
      ALU_SLL:  r.out = a << sh;
      ALU_SRL:  r.out = a >> sh;
      ALU_ADD:  r.out = a + b;
      ALU_SUB:  r.out = a - b;
      ALU_AND:  r.out = a & b;
      ALU_OR:   r.out = a | b;
      ALU_XOR:  r.out = a ^ b;
      ALU_NOR:  r.out = ~(a | b);
      ALU_SLT:  r.out = {31'd0, $signed(a) < $signed(b)};
      ALU_SLTU: r.out = {31'd0, a < b};
      default:  r.out = '0;
    endcase
    if (op == ALU_ADD) r.ovf = (a[31] == b[31]) && (r.out[31] != a[31]);
    if (op == ALU_SUB) r.ovf = (a[31] != b[31]) && (r.out[31] != a[31]);
    r.neg  = r.out[31];
    r.zero = (r.out == 32'd0);
    return r;
  endfunction

  // Behavioural ALU the arbiter drives.
  always_comb begin
    alu_res = alu_ref(alu_aluop, alu_ra, alu_rb);
  end
  assign alu_out      = alu_res.out;
  assign alu_negative = alu_res.neg;
  assign alu_overflow = alu_res.ovf;
  assign alu_zero     = alu_res.zero;

  // Reference model: an operation granted at edge e completes at e+1; its ack is the cycle after that edge.
  int          cyc = -1;
  int          done_edge = -1;
  int          ack_edge [2] = '{-5, -5};
  int          cur = 0;
  logic        m_last = 1'b1;
  logic        m_gnt = 1'b0;
  res_t        m_res [2];
  res_t        pend;
  aluop_t      m_op = ALU_SLL;
  logic [31:0] m_ra = '0;
  logic [31:0] m_rb = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: got=%h expected=%h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_edge();
    logic e0, e1;
    cyc++;
    if (RST) begin
      done_edge   = -1;
      ack_edge[0] = -5;
      ack_edge[1] = -5;
      m_last      = 1'b1;
      m_gnt       = 1'b0;
      m_res[0]    = '0;
      m_res[1]    = '0;
      m_op        = aluop_t'(4'd0);
      m_ra        = '0;
      m_rb        = '0;
    end else if (done_edge == cyc) begin
      m_res[cur]    = pend;
      ack_edge[cur] = cyc;
      m_last        = (cur == 1);
      done_edge     = -1;
    end else begin
      e0 = req0 && (ack_edge[0] != cyc - 1);
      e1 = req1 && (ack_edge[1] != cyc - 1);
      if (e0 || e1) begin
        if (e0 && e1) cur = m_last ? 0 : 1;
        else          cur = e1 ? 1 : 0;
        m_gnt = (cur == 1);
        if (cur == 1) begin m_op = aluop1; m_ra = ra1; m_rb = rb1; end
        else          begin m_op = aluop0; m_ra = ra0; m_rb = rb0; end
        pend      = alu_ref(m_op, m_ra, m_rb);
        done_edge = cyc + 1;
      end
    end
  endtask

  task automatic compare_all();
    check("busy", 32'(busy), 32'(done_edge == cyc + 1));
    check("gnt", 32'(gnt), 32'(m_gnt));
    check("ack0", 32'(ack0), 32'(ack_edge[0] == cyc));
    check("ack1", 32'(ack1), 32'(ack_edge[1] == cyc));
    check("out0", out0, m_res[0].out);
    check("negative0", 32'(negative0), 32'(m_res[0].neg));
    check("overflow0", 32'(overflow0), 32'(m_res[0].ovf));
    check("zero0", 32'(zero0), 32'(m_res[0].zero));
    check("out1", out1, m_res[1].out);
    check("negative1", 32'(negative1), 32'(m_res[1].neg));
    check("overflow1", 32'(overflow1), 32'(m_res[1].ovf));
    check("zero1", 32'(zero1), 32'(m_res[1].zero));
    check("alu_aluop", 32'(alu_aluop), 32'(m_op));
    check("alu_ra", alu_ra, m_ra);
    check("alu_rb", alu_rb, m_rb);
    check("ack_exclusive", 32'(ack0 & ack1), 32'd0);
    check("busy_ack_exclusive", 32'(busy & (ack0 | ack1)), 32'd0);
  endtask

  task automatic step();
    @(posedge CLK);
    model_edge();
    @(negedge CLK);
    compare_all();
  endtask

  function automatic logic [31:0] rand_word();
    case ($urandom_range(0, 3))
      0:       return 32'h7fff_ffff;
      1:       return 32'h8000_0000;
      2:       return 32'($urandom_range(0, 15));
      default: return $urandom();
    endcase
  endfunction

  task automatic rand_ops0();
    aluop0 = aluop_t'(4'($urandom_range(0, 9)));
    ra0    = rand_word();
    rb0    = rand_word();
  endtask

  task automatic rand_ops1();
    aluop1 = aluop_t'(4'($urandom_range(0, 9)));
    ra1    = rand_word();
    rb1    = rand_word();
  endtask

  initial begin
    int   last_ack0, last_ack1, n_grants, a1;
    logic exp_g;

    RST = 1'b1;
    req0 = 1'b0; req1 = 1'b0;
    aluop0 = ALU_ADD; aluop1 = ALU_ADD;
    ra0 = '0; rb0 = '0; ra1 = '0; rb1 = '0;
    step();
    step();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_out0", out0, 32'd0);
    RST = 1'b0;

    // Single request: ADD 5+7.
    req0 = 1'b1; aluop0 = ALU_ADD; ra0 = 32'd5; rb0 = 32'd7;
    step();
    check("tp1_busy", 32'(busy), 32'd1);
    check("tp1_ack0_early", 32'(ack0), 32'd0);
    step();
    req0 = 1'b0;
    check("tp1_ack0", 32'(ack0), 32'd1);
    check("tp1_out0", out0, 32'd12);
    check("tp1_flags0", {29'd0, zero0, negative0, overflow0}, 32'd0);
    step();
    check("tp1_ack0_single", 32'(ack0), 32'd0);
    check("tp1_out1", out1, 32'd0);

    // First tie after reset goes to port 0.
    RST = 1'b1; step(); RST = 1'b0;
    req0 = 1'b1; aluop0 = ALU_SUB; ra0 = 32'd9; rb0 = 32'd9;
    req1 = 1'b1; aluop1 = ALU_ADD; ra1 = 32'd1; rb1 = 32'd2;
    step();
    check("tp2_gnt0", 32'(gnt), 32'd0);
    step();
    req0 = 1'b0;
    check("tp2_ack0", 32'(ack0), 32'd1);
    check("tp2_out0", out0, 32'd0);
    check("tp2_zero0", 32'(zero0), 32'd1);
    step();
    check("tp2_gnt1", 32'(gnt), 32'd1);
    step();
    req1 = 1'b0;
    check("tp2_ack1", 32'(ack1), 32'd1);
    check("tp2_out1", out1, 32'd3);
    check("tp2_out0_held", out0, 32'd0);
    step();

    // Sustained contention for 12 cycles.
    req0 = 1'b1; req1 = 1'b1;
    rand_ops0(); rand_ops1();
    exp_g = 1'b0; n_grants = 0; last_ack0 = -1; last_ack1 = -1;
    for (int i = 0; i < 12; i++) begin
      step();
      if (busy) begin
        check("tp3_gnt_seq", 32'(gnt), 32'(exp_g));
        exp_g = ~exp_g;
        n_grants++;
      end
      if (ack0) begin
        if (last_ack0 >= 0) check("tp3_ack0_gap", 32'(cyc - last_ack0), 32'd4);
        last_ack0 = cyc;
        rand_ops0();
      end
      if (ack1) begin
        if (last_ack1 >= 0) check("tp3_ack1_gap", 32'(cyc - last_ack1), 32'd4);
        last_ack1 = cyc;
        rand_ops1();
      end
    end
    check("tp3_n_grants", 32'(n_grants), 32'd6);
    req0 = 1'b0; req1 = 1'b0;
    step();
    step();

    // Overflow result held while the other port completes.
    req1 = 1'b1; aluop1 = ALU_ADD; ra1 = 32'h7fff_ffff; rb1 = 32'd1;
    step();
    step();
    check("tp4_out1", out1, 32'h8000_0000);
    check("tp4_ovf1", 32'(overflow1), 32'd1);
    check("tp4_neg1", 32'(negative1), 32'd1);
    req1 = 1'b0;
    req0 = 1'b1; aluop0 = ALU_ADD; ra0 = 32'd2; rb0 = 32'd2;
    step();
    step();
    req0 = 1'b0;
    check("tp4_out0", out0, 32'd4);
    check("tp4_out1_held", out1, 32'h8000_0000);
    check("tp4_ovf1_held", 32'(overflow1), 32'd1);
    check("tp4_neg1_held", 32'(negative1), 32'd1);
    step();

    // Reset in the BUSY cycle discards the operation.
    req0 = 1'b1; aluop0 = ALU_ADD; ra0 = 32'd3; rb0 = 32'd4;
    step();
    check("tp5_busy", 32'(busy), 32'd1);
    RST = 1'b1;
    step();
    RST = 1'b0; req0 = 1'b0;
    check("tp5_out0", out0, 32'd0);
    check("tp5_out1", out1, 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("tp5_no_ack0", 32'(ack0), 32'd0);
    end
    req0 = 1'b1; req1 = 1'b1;
    step();
    check("tp5_tie_gnt", 32'(gnt), 32'd0);
    step();
    req0 = 1'b0;
    step();
    step();
    req1 = 1'b0;
    step();

    // Held req0 skips its own ack cycle: ack-to-ack spacing is 3.
    req0 = 1'b1; aluop0 = ALU_ADD; ra0 = 32'd10; rb0 = 32'd20;
    step();
    step();
    check("tp6_ack0", 32'(ack0), 32'd1);
    a1 = cyc;
    step();
    check("tp6_no_grant_in_ack", 32'(busy), 32'd0);
    step();
    check("tp6_regrant", 32'(busy), 32'd1);
    step();
    check("tp6_ack0_again", 32'(ack0), 32'd1);
    check("tp6_ack_gap", 32'(cyc - a1), 32'd3);
    req0 = 1'b0;
    step();

    // Random traffic with occasional resets.
    for (int i = 0; i < 2000; i++) begin
      RST = ($urandom_range(0, 59) == 0);
      if (req0 && ack_edge[0] == cyc) begin
        if ($urandom_range(0, 1) == 0) req0 = 1'b0;
        else rand_ops0();
      end else if (!req0) begin
        if ($urandom_range(0, 2) == 0) begin req0 = 1'b1; rand_ops0(); end
      end else if ($urandom_range(0, 7) == 0) begin
        rand_ops0();
      end
      if (req1 && ack_edge[1] == cyc) begin
        if ($urandom_range(0, 1) == 0) req1 = 1'b0;
        else rand_ops1();
      end else if (!req1) begin
        if ($urandom_range(0, 2) == 0) begin req1 = 1'b1; rand_ops1(); end
      end else if ($urandom_range(0, 7) == 0) begin
        rand_ops1();
      end
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
